// File: rtl/reorder_tag_manager_pkg.sv
// Shared types for the reorder path: per-tag verdict status encodings used by
// the tag manager and the circular buffer that drains against it.
package reorder_tag_manager_pkg;

  typedef enum logic [1:0] {
    STATUS_PENDING  = 2'b00,
    STATUS_REJECTED = 2'b01,
    STATUS_ACCEPTED = 2'b11
  } status_e;

  function automatic status_e verdict_status(input logic accept);
    return accept ? STATUS_ACCEPTED : STATUS_REJECTED;
  endfunction

endpackage

// File: rtl/reorder_tag_if.sv
// Bundle of upstream stream, filter verdict and buffer drain/release signals
// around the reorder tag manager; slave is the manager's view.
interface reorder_tag_if #(
    parameter int TAG_WIDTH = 6
);
    import reorder_tag_manager_pkg::*;

    logic                 in_TVALID;
    logic                 in_TLAST;
    logic                 buffer_TREADY;
    logic                 in_TREADY;
    logic [TAG_WIDTH-1:0] reorder_tag_in;
    logic                 verdict_valid;
    logic [TAG_WIDTH-1:0] verdict_tag;
    logic                 verdict_accept;
    logic [TAG_WIDTH-1:0] reorder_tag_out;
    status_e              packet_status;
    logic                 release_valid;
    logic [TAG_WIDTH-1:0] release_tag;
    logic [TAG_WIDTH:0]   in_flight;
    logic                 err;

    modport master (
        output in_TVALID, in_TLAST, buffer_TREADY, verdict_valid, verdict_tag,
               verdict_accept, reorder_tag_out, release_valid, release_tag,
        input  in_TREADY, reorder_tag_in, packet_status, in_flight, err
    );

    modport slave (
        input  in_TVALID, in_TLAST, buffer_TREADY, verdict_valid, verdict_tag,
               verdict_accept, reorder_tag_out, release_valid, release_tag,
        output in_TREADY, reorder_tag_in, packet_status, in_flight, err
    );

endinterface

// File: rtl/reorder_status_table.sv
// Per-tag used bit and verdict status with allocate/verdict/release write
// ports, legality flags for each port and one asynchronous status read port.
module reorder_status_table
    import reorder_tag_manager_pkg::*;
#(
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_we_i,
    input  logic [TAG_WIDTH-1:0] alloc_tag_i,
    input  logic                 verdict_valid_i,
    input  logic [TAG_WIDTH-1:0] verdict_tag_i,
    input  logic                 verdict_accept_i,
    input  logic                 release_valid_i,
    input  logic [TAG_WIDTH-1:0] release_tag_i,
    input  logic [TAG_WIDTH-1:0] rd_tag_i,
    output status_e              rd_status_o,
    output logic                 alloc_free_o,
    output logic                 verdict_ok_o,
    output logic                 release_ok_o
);
    // Full power-of-two storage keeps indexing width-exact; entries at or
    // beyond DEPTH are never written and read back as free/PENDING.
    localparam int ENTRIES = 1 << TAG_WIDTH;

    logic [ENTRIES-1:0] used_q;
    status_e            status_q [ENTRIES];

    always_comb begin
        alloc_free_o = !used_q[alloc_tag_i];
        verdict_ok_o = verdict_valid_i && (int'(verdict_tag_i) < DEPTH) &&
                       used_q[verdict_tag_i] && (status_q[verdict_tag_i] == STATUS_PENDING);
        release_ok_o = release_valid_i && (int'(release_tag_i) < DEPTH) &&
                       used_q[release_tag_i] && (status_q[release_tag_i] != STATUS_PENDING);
        rd_status_o  = status_q[rd_tag_i];
    end

    // NOTE: the table is small and must read clean straight after reset, so
    // every entry is cleared rather than left as an unreset RAM.
    // NOTE: non-blocking assignments here so all ports see pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
            for (int i = 0; i < ENTRIES; i++) status_q[i] <= STATUS_PENDING;
        end else begin
            if (alloc_we_i) begin
                used_q[alloc_tag_i]   <= 1'b1;
                status_q[alloc_tag_i] <= STATUS_PENDING;
            end
            if (verdict_ok_o) status_q[verdict_tag_i] <= verdict_status(verdict_accept_i);
            if (release_ok_o) begin
                used_q[release_tag_i]   <= 1'b0;
                status_q[release_tag_i] <= STATUS_PENDING;
            end
        end
    end

endmodule

// File: rtl/reorder_tag_manager.sv
// Stamps inbound packets with circular reorder tags, tracks filter verdicts
// per tag and recycles tags once the buffer has drained or dropped them.
module reorder_tag_manager
    import reorder_tag_manager_pkg::*;
#(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50
) (
    input logic          clk,
    input logic          rst,
    reorder_tag_if.slave bus
);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [TAG_WIDTH:0]   ONE      = (TAG_WIDTH + 1)'(1);

    logic [TAG_WIDTH-1:0] next_tag_q, next_tag_d;
    logic                 mid_packet_q, mid_packet_d;
    logic [TAG_WIDTH:0]   in_flight_q, in_flight_d;
    logic                 err_q, err_d;

    logic alloc_free, verdict_ok, release_ok;
    logic tag_avail, handshake, alloc;

    // Only the first beat needs a free slot; later beats reuse the held tag.
    assign tag_avail     = mid_packet_q | alloc_free;
    assign bus.in_TREADY = bus.buffer_TREADY & tag_avail;
    assign handshake     = bus.in_TVALID & bus.in_TREADY;
    assign alloc         = handshake & ~mid_packet_q;

    reorder_status_table #(
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (CIRCULAR_BUFFER_SIZE)
    ) u_table (
        .clk              (clk),
        .rst              (rst),
        .alloc_we_i       (alloc),
        .alloc_tag_i      (next_tag_q),
        .verdict_valid_i  (bus.verdict_valid),
        .verdict_tag_i    (bus.verdict_tag),
        .verdict_accept_i (bus.verdict_accept),
        .release_valid_i  (bus.release_valid),
        .release_tag_i    (bus.release_tag),
        .rd_tag_i         (bus.reorder_tag_out),
        .rd_status_o      (bus.packet_status),
        .alloc_free_o     (alloc_free),
        .verdict_ok_o     (verdict_ok),
        .release_ok_o     (release_ok)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the branches below can infer a latch.
        next_tag_d   = next_tag_q;
        mid_packet_d = mid_packet_q;
        in_flight_d  = in_flight_q;
        err_d        = (bus.verdict_valid & ~verdict_ok) | (bus.release_valid & ~release_ok);

        if (handshake) begin
            mid_packet_d = ~bus.in_TLAST;
            if (bus.in_TLAST)
                next_tag_d = (next_tag_q == LAST_TAG) ? '0 : next_tag_q + TAG_WIDTH'(1);
        end

        unique case ({alloc, release_ok})
            2'b10:   in_flight_d = in_flight_q + ONE;
            2'b01:   in_flight_d = in_flight_q - ONE;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_tag_q   <= '0;
            mid_packet_q <= 1'b0;
            in_flight_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            next_tag_q   <= next_tag_d;
            mid_packet_q <= mid_packet_d;
            in_flight_q  <= in_flight_d;
            err_q        <= err_d;
        end
    end

    assign bus.reorder_tag_in = next_tag_q;
    assign bus.in_flight      = in_flight_q;
    assign bus.err            = err_q;

endmodule

// File: doc/reorder_tag_manager.md
REORDER_TAG_MANAGER -- requirements
Module: reorder_tag_manager

Interface
REQ-001 Parameter TAG_WIDTH, default 6, width of every reorder tag.
REQ-002 Parameter CIRCULAR_BUFFER_SIZE, default 50, number of tags/buffer slots; tags range 0..CIRCULAR_BUFFER_SIZE-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_TVALID  input  1  upstream packet stream valid (monitored).
REQ-007 in_TLAST  input  1  upstream last beat (monitored).
REQ-008 buffer_TREADY  input  1  ready from the circular buffer's input port.
REQ-009 in_TREADY  output  1  ready returned upstream = buffer_TREADY AND tag_avail.
REQ-010 reorder_tag_in  output  TAG_WIDTH  tag stamped on the current inbound packet.
REQ-011 verdict_valid  input  1  filter verdict strobe.
REQ-012 verdict_tag  input  TAG_WIDTH  tag the verdict applies to.
REQ-013 verdict_accept  input  1  1 = accept, 0 = reject.
REQ-014 reorder_tag_out  input  TAG_WIDTH  tag the buffer is draining/querying.
REQ-015 packet_status  output  2  status of reorder_tag_out: 00 pending, 01 rejected, 11 accepted.
REQ-016 release_valid  input  1  buffer finished draining/dropping release_tag.
REQ-017 release_tag  input  TAG_WIDTH  tag being returned.
REQ-018 in_flight  output  TAG_WIDTH+1  count of allocated tags.
REQ-019 err  output  1  one-cycle pulse on an illegal verdict or release.

Function
REQ-020 Per-tag table SHALL hold used bit and 2-bit status; free entries read as PENDING.
REQ-021 next_tag counter SHALL name the tag for the current/next packet; reorder_tag_in = next_tag, stable for all beats of a packet.
REQ-022 A beat is a handshake (in_TVALID AND in_TREADY); first handshake while not mid-packet SHALL set entry[next_tag] used, status PENDING, set mid_packet.
REQ-023 Handshake with in_TLAST SHALL clear mid_packet and advance next_tag, wrapping CIRCULAR_BUFFER_SIZE-1 -> 0; single-beat packet allocates and advances in the same cycle.
REQ-024 tag_avail SHALL be 1 when mid_packet OR entry[next_tag] not used; otherwise in_TREADY SHALL be 0 (full stall, no tag overwrite).
REQ-025 Verdict on a used PENDING entry SHALL set status 11 (accept) or 01 (reject), visible on packet_status the next cycle.
REQ-026 Verdict on a free or already-decided entry, or tag >= CIRCULAR_BUFFER_SIZE, SHALL be ignored and pulse err next cycle.
REQ-027 Release on a used, decided entry SHALL clear used and reset status to PENDING; release of a free or PENDING entry SHALL be ignored and pulse err.
REQ-028 packet_status SHALL be a combinational read of entry[reorder_tag_out] (zero latency from reorder_tag_out).
REQ-029 in_flight SHALL increment on allocation, decrement on legal release; simultaneous both -> unchanged; never exceeds CIRCULAR_BUFFER_SIZE.
REQ-030 Same-cycle verdict and allocation on the same tag: verdict judged on pre-edge state (entry free) -> ignored, err.
REQ-031 Same-cycle release of next_tag and stalled allocation: release completes; allocation proceeds the following cycle.
REQ-032 Same-cycle verdict and release on different tags SHALL both take effect.

Reset
REQ-033 On rst: all entries free/PENDING, next_tag 0, mid_packet 0, in_flight 0, err 0; reorder_tag_in 0, in_TREADY = buffer_TREADY.
REQ-034 Reset mid-packet SHALL abandon the packet; no partial state survives; rst has priority over all strobes.

Structure
REQ-035 Status encodings PENDING/REJECTED/ACCEPTED SHALL live in a shared package used by this block and circular_buffer.
REQ-036 The table SHALL be one sub-module, reorder_status_table (allocate, verdict, release write ports; one async read port).

Verification (CIRCULAR_BUFFER_SIZE=3)
REQ-037 Three 2-beat packets, no releases -> tags 0,1,2; in_flight=3; fourth packet: in_TREADY=0 with buffer_TREADY=1.
REQ-038 Verdicts tag1 accept, tag0 reject -> packet_status 11 for reorder_tag_out=1, 01 for 0, 00 for 2.
REQ-039 Full, release tag0 (decided) -> next cycle in_TREADY=1, next packet gets tag 0 (wrap), in_flight returns to 3.
REQ-040 Release of PENDING tag2 and verdict to free tag -> err pulses each, table unchanged.
REQ-041 Single-beat packet plus same-cycle verdict on its tag -> err=1, status stays 00; later verdict accept -> 11.
REQ-042 rst asserted mid-packet on tag1 -> all entries 00, in_flight 0, next packet tagged 0.
